// File: rtl/game_phase_sequencer_pkg.sv
// Shared types and constants for the game phase sequencer and the blocks
// that display or score its phases.
package game_phase_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRELIM,
        ST_GAME,
        ST_ANSWER,
        ST_POST,
        ST_OVER
    } phase_state_t;

    localparam int SEC_W   = 7;
    localparam int LEVEL_W = 5;

    localparam int DEF_PRELIM_SEC = 3;
    localparam int DEF_GAME_SEC   = 20;
    localparam int DEF_ANSWER_SEC = 10;
    localparam int DEF_POST_SEC   = 3;

endpackage

// File: rtl/game_phase_sequencer_phase_timer.sv
// Loadable down-counter holding the seconds left in the current phase.
// expire flags the tick that consumes the last second.
module phase_timer
    import game_phase_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [SEC_W-1:0] load_value,
    input  logic             tick,
    input  logic             hold,
    output logic [SEC_W-1:0] count,
    output logic             expire
);

    assign expire = (count == SEC_W'(1)) && tick && !hold;

    // The final second is never decremented to 0; the owner reloads instead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (tick && !hold && (count > SEC_W'(1))) begin
            count <= count - SEC_W'(1);
        end
    end

endmodule

// File: rtl/game_phase_sequencer.sv
// Level/phase sequencer for the counting game: PRELIM -> GAME -> ANSWER -> POST.
// Define GAME_SEQ_PAUSE_EN to add a level-sensitive pause input.
module game_phase_sequencer
    import game_phase_sequencer_pkg::*;
#(
    parameter int PRELIM_SEC = DEF_PRELIM_SEC,
    parameter int GAME_SEC   = DEF_GAME_SEC,
    parameter int ANSWER_SEC = DEF_ANSWER_SEC,
    parameter int POST_SEC   = DEF_POST_SEC,
    parameter int MAX_LEVEL  = 5
) (
    input  logic               Clk100M,
    input  logic               reset,
    input  logic               Clk1Hz,
    input  logic               start,
    input  logic               answerValid,
    input  logic               answerCorrect,
`ifdef GAME_SEQ_PAUSE_EN
    input  logic               pause,
`endif
    output logic               prelimPeriod,
    output logic               gamePeriod,
    output logic               answerPeriod,
    output logic               postPeriod,
    output logic               levelChng,
    output logic               clkReset,
    output logic [LEVEL_W-1:0] level,
    output logic [SEC_W-1:0]   secondsLeft,
    output logic               gameOver,
    output logic               gameWon
);

    phase_state_t       state_q, state_d;
    logic [LEVEL_W-1:0] level_d;
    logic               win_q, win_d;
    logic               won_d, level_chng_d, clk_reset_d;
    logic               prelim_d, game_d, answer_d, post_d, over_d;
    logic               load;
    logic [SEC_W-1:0]   load_value;
    logic               expire;
    logic               hold;
    logic               start_ok, answer_ok;

`ifdef GAME_SEQ_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    assign start_ok  = start && !hold;
    assign answer_ok = answerValid && !hold;

    phase_timer u_timer (
        .clk        (Clk100M),
        .rst_n      (reset),
        .load       (load),
        .load_value (load_value),
        .tick       (Clk1Hz),
        .hold       (hold),
        .count      (secondsLeft),
        .expire     (expire)
    );

    always_ff @(posedge Clk100M or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            level        <= LEVEL_W'(1);
            win_q        <= 1'b0;
            gameWon      <= 1'b0;
            gameOver     <= 1'b0;
            levelChng    <= 1'b0;
            clkReset     <= 1'b0;
            prelimPeriod <= 1'b0;
            gamePeriod   <= 1'b0;
            answerPeriod <= 1'b0;
            postPeriod   <= 1'b0;
        end else begin
            state_q      <= state_d;
            level        <= level_d;
            win_q        <= win_d;
            gameWon      <= won_d;
            gameOver     <= over_d;
            levelChng    <= level_chng_d;
            clkReset     <= clk_reset_d;
            prelimPeriod <= prelim_d;
            gamePeriod   <= game_d;
            answerPeriod <= answer_d;
            postPeriod   <= post_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        level_d      = level;
        win_d        = win_q;
        won_d        = gameWon;
        level_chng_d = 1'b0;
        clk_reset_d  = 1'b0;
        load         = 1'b0;
        load_value   = '0;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_ok) begin
                    state_d     = ST_PRELIM;
                    level_d     = LEVEL_W'(1);
                    win_d       = 1'b0;
                    won_d       = 1'b0;
                    clk_reset_d = 1'b1;
                    load        = 1'b1;
                    load_value  = SEC_W'(PRELIM_SEC);
                end
            end
            ST_PRELIM: begin
                if (expire) begin
                    state_d    = ST_GAME;
                    load       = 1'b1;
                    load_value = SEC_W'(GAME_SEC);
                end
            end
            ST_GAME: begin
                if (expire) begin
                    state_d    = ST_ANSWER;
                    load       = 1'b1;
                    load_value = SEC_W'(ANSWER_SEC);
                end
            end
            // A submitted answer wins over a timeout landing on the same edge.
            ST_ANSWER: begin
                if (answer_ok) begin
                    state_d    = ST_POST;
                    win_d      = answerCorrect;
                    load       = 1'b1;
                    load_value = SEC_W'(POST_SEC);
                end else if (expire) begin
                    state_d    = ST_POST;
                    win_d      = 1'b0;
                    load       = 1'b1;
                    load_value = SEC_W'(POST_SEC);
                end
            end
            ST_POST: begin
                if (expire) begin
                    load = 1'b1;
                    if (win_q && (level < LEVEL_W'(MAX_LEVEL))) begin
                        state_d      = ST_PRELIM;
                        level_d      = level + LEVEL_W'(1);
                        level_chng_d = 1'b1;
                        load_value   = SEC_W'(PRELIM_SEC);
                    end else begin
                        state_d    = ST_OVER;
                        won_d      = win_q;
                        load_value = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pausing drops gamePeriod so the divider stops generating symbols.
    always_comb begin
        prelim_d = (state_d == ST_PRELIM);
        game_d   = (state_d == ST_GAME) && !hold;
        answer_d = (state_d == ST_ANSWER);
        post_d   = (state_d == ST_POST);
        over_d   = (state_d == ST_OVER);
    end

endmodule

// File: tb/tb_game_phase_sequencer.sv
// Directed scoreboard bench for game_phase_sequencer with short phase lengths.
// Expected values are queued as each step is driven and popped on comparison.
module tb_game_phase_sequencer;

    logic       Clk100M = 1'b0;
    logic       reset = 1'b0;
    logic       Clk1Hz = 1'b0;
    logic       start = 1'b0;
    logic       answerValid = 1'b0;
    logic       answerCorrect = 1'b0;
`ifdef GAME_SEQ_PAUSE_EN
    logic       pause = 1'b0;
`endif
    logic       prelimPeriod, gamePeriod, answerPeriod, postPeriod;
    logic       levelChng, clkReset, gameOver, gameWon;
    logic [4:0] level;
    logic [6:0] secondsLeft;

    int checks = 0;
    int failures = 0;
    logic [31:0] expQ[$];

    localparam logic [3:0] PH_P = 4'b1000;
    localparam logic [3:0] PH_G = 4'b0100;
    localparam logic [3:0] PH_A = 4'b0010;
    localparam logic [3:0] PH_O = 4'b0001;
    localparam logic [3:0] PH_N = 4'b0000;

    game_phase_sequencer #(
        .PRELIM_SEC (2),
        .GAME_SEC   (3),
        .ANSWER_SEC (2),
        .POST_SEC   (1),
        .MAX_LEVEL  (2)
    ) dut (
        .Clk100M       (Clk100M),
        .reset         (reset),
        .Clk1Hz        (Clk1Hz),
        .start         (start),
        .answerValid   (answerValid),
        .answerCorrect (answerCorrect),
`ifdef GAME_SEQ_PAUSE_EN
        .pause         (pause),
`endif
        .prelimPeriod  (prelimPeriod),
        .gamePeriod    (gamePeriod),
        .answerPeriod  (answerPeriod),
        .postPeriod    (postPeriod),
        .levelChng     (levelChng),
        .clkReset      (clkReset),
        .level         (level),
        .secondsLeft   (secondsLeft),
        .gameOver      (gameOver),
        .gameWon       (gameWon)
    );

    always #5 Clk100M = ~Clk100M;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one clock cycle of inputs; returns 1ns after the consuming edge.
    task automatic applyStimulus(input logic s, input logic av, input logic ac, input logic hz);
        start = s;
        answerValid = av;
        answerCorrect = ac;
        Clk1Hz = hz;
        @(posedge Clk100M);
        #1;
        start = 1'b0;
        answerValid = 1'b0;
        answerCorrect = 1'b0;
        Clk1Hz = 1'b0;
    endtask

    task automatic secTick();
        repeat (9) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        checks++;
        if (expQ.size() == 0) begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=<empty queue>", tag, obs);
        end else begin
            exp = expQ.pop_front();
            assert (obs === exp) else begin
                failures++;
                $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            end
        end
    endtask

    // Phase word: {prelim, game, answer, post, secondsLeft}
    task automatic expectPhase(input string tag, input logic [3:0] per, input int sec);
        expQ.push_back({21'b0, per, 7'(sec)});
        checkOutput(tag, {21'b0, prelimPeriod, gamePeriod, answerPeriod, postPeriod, secondsLeft});
    endtask

    // Flag word: {gameOver, gameWon, levelChng, clkReset, level}
    task automatic expectFlags(input string tag, input logic over, input logic won,
                               input logic lc, input logic cr, input int lvl);
        expQ.push_back({23'b0, over, won, lc, cr, 5'(lvl)});
        checkOutput(tag, {23'b0, gameOver, gameWon, levelChng, clkReset, level});
    endtask

    initial begin
        repeat (3) @(posedge Clk100M);
        #1;
        expectPhase("rst_phase", PH_N, 0);
        expectFlags("rst_flags", 0, 0, 0, 0, 1);
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0);

        $display("[TB] level 1 walk-through");
        applyStimulus(1, 0, 0, 0);
        expectPhase("start_prelim", PH_P, 2);
        expectFlags("start_flags", 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0);
        expectFlags("clkreset_drop", 0, 0, 0, 0, 1);
        secTick();
        expectPhase("prelim_dec", PH_P, 1);
        secTick();
        expectPhase("game_entry", PH_G, 3);
        repeat (3) secTick();
        expectPhase("answer_entry", PH_A, 2);
        applyStimulus(0, 1, 1, 0);
        expectPhase("post_entry", PH_O, 1);
        secTick();
        expectFlags("level_up", 0, 0, 1, 0, 2);
        expectPhase("prelim_l2", PH_P, 2);
        applyStimulus(0, 0, 0, 0);
        expectFlags("levelchng_drop", 0, 0, 0, 0, 2);

        $display("[TB] final level win");
        repeat (5) secTick();
        expectPhase("answer_l2", PH_A, 2);
        applyStimulus(0, 1, 1, 0);
        secTick();
        expectFlags("won_flags", 1, 1, 0, 0, 2);
        expectPhase("won_phase", PH_N, 0);
        secTick();
        expectFlags("over_hold", 1, 1, 0, 0, 2);

        $display("[TB] timeout loss and restart");
        applyStimulus(1, 0, 0, 0);
        expectFlags("restart_flags", 0, 0, 0, 1, 1);
        applyStimulus(0, 1, 1, 0);
        expectPhase("av_ignored", PH_P, 2);
        repeat (5) secTick();
        expectPhase("answer_wait", PH_A, 2);
        secTick();
        expectPhase("answer_dec", PH_A, 1);
        secTick();
        expectPhase("timeout_post", PH_O, 1);
        secTick();
        expectFlags("lost_flags", 1, 0, 0, 0, 1);
        expectPhase("lost_phase", PH_N, 0);

        $display("[TB] answer on final tick");
        applyStimulus(1, 0, 0, 0);
        expectFlags("restart2_flags", 0, 0, 0, 1, 1);
        repeat (6) secTick();
        expectPhase("answer_last", PH_A, 1);
        repeat (9) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 1, 1);
        expectPhase("tie_post", PH_O, 1);
        secTick();
        expectFlags("tie_level_up", 0, 0, 1, 0, 2);

        $display("[TB] async reset mid-game");
        repeat (2) secTick();
        expectPhase("game_l2", PH_G, 3);
        applyStimulus(1, 0, 0, 0);
        expectFlags("start_ignored", 0, 0, 0, 0, 2);
        secTick();
        expectPhase("game_dec", PH_G, 2);
        #3 reset = 1'b0;
        #1;
        expectPhase("async_rst_phase", PH_N, 0);
        expectFlags("async_rst_flags", 0, 0, 0, 0, 1);
        #1 reset = 1'b1;
        applyStimulus(0, 0, 0, 0);

`ifdef GAME_SEQ_PAUSE_EN
        $display("[TB] pause in game");
        applyStimulus(1, 0, 0, 0);
        repeat (2) secTick();
        expectPhase("pause_game_entry", PH_G, 3);
        pause = 1'b1;
        applyStimulus(0, 0, 0, 0);
        expectPhase("pause_gate", PH_N, 3);
        repeat (3) secTick();
        expectPhase("pause_hold", PH_N, 3);
        pause = 1'b0;
        applyStimulus(0, 0, 0, 0);
        expectPhase("pause_release", PH_G, 3);
        secTick();
        expectPhase("pause_resume", PH_G, 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_phase_sequencer.md
Name: game_phase_sequencer

Overview:
- Drives the game-period and level inputs of the clock divider and consumes its `Clk1Hz` tick.
- Sequences each level through four phases: prelim, game, answer, post. Advances the level on a correct answer and ends the game on a wrong answer, a timeout, or clearing `MAX_LEVEL`.
- Exposes the seconds remaining in the current phase for the 7-segment display path.

Parameters:
- PRELIM_SEC, 3, prelim phase length in `Clk1Hz` ticks (1..127)
- GAME_SEC, 20, game phase length in ticks (1..127)
- ANSWER_SEC, 10, answer window length in ticks (1..127)
- POST_SEC, 3, post phase length in ticks (1..127)
- MAX_LEVEL, 5, final level. 5 keeps the divider's cumulative `level*5000000` decrement below 100000000.

Ports:
- Clk100M  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-low; low forces IDLE
- Clk1Hz  in  1  one-Clk100M-cycle tick, once per second
- start  in  1  one-cycle pulse from the debounced start button
- answerValid  in  1  one-cycle pulse: player submitted a count
- answerCorrect  in  1  qualifies answerValid; sampled only with it
- prelimPeriod  out  1  high throughout PRELIM
- gamePeriod  out  1  high throughout GAME
- answerPeriod  out  1  high throughout ANSWER
- postPeriod  out  1  high throughout POST
- levelChng  out  1  one-cycle pulse when level increments
- clkReset  out  1  one-cycle pulse on game start; restarts the divider
- level  out  5  current level, 1..MAX_LEVEL
- secondsLeft  out  7  ticks remaining in current phase; 0 in IDLE/OVER
- gameOver  out  1  high in OVER
- gameWon  out  1  valid while gameOver; 1 = MAX_LEVEL cleared

Behaviour:
- **States:** IDLE, PRELIM, GAME, ANSWER, POST, OVER. All outputs are registered.
- **Reset values:** IDLE; level=1; secondsLeft=0; every other output 0.
- **Period outputs:** one-hot among prelim/game/answer/post; all low in IDLE and OVER.
- **Phase timing:**
  - On phase entry, secondsLeft loads that phase's *_SEC.
  - A Clk1Hz tick with secondsLeft>1 decrements it.
  - A tick with secondsLeft==1 ends the phase on that edge.
  - Each phase therefore lasts exactly *_SEC ticks.
- **IDLE/OVER:**
  - start pulse → PRELIM, level=1, gameOver=0, gameWon=0.
  - clkReset is pulsed for that one cycle.
  - levelChng is NOT pulsed.
- **Phase order:** PRELIM → GAME → ANSWER on expiry.
- **ANSWER:**
  - answerValid → POST immediately, latching win = answerCorrect.
  - Expiry with no answer → POST with win=0.
  - answerValid and the final tick in the same cycle: answerValid takes priority.
- **POST expiry:**
  - win and level<MAX_LEVEL → level+1, levelChng=1 for one cycle (the same edge level updates), → PRELIM.
  - win and level==MAX_LEVEL → OVER, gameWon=1.
  - Otherwise → OVER, gameWon=0.
- **Ignored inputs:** start outside IDLE/OVER; answerValid outside ANSWER; Clk1Hz in IDLE/OVER.
- **Mid-operation reset:** reset low at any time returns asynchronously to IDLE with reset values; no pulses are emitted.
- **Pulse exclusivity:** levelChng and clkReset never assert in the same cycle.

Optional Feature:
- **Macro:** GAME_SEQ_PAUSE_EN.
- **When defined:**
  - Adds input port `pause` (1 bit, level).
  - While pause=1: Clk1Hz, answerValid and start are ignored; state, secondsLeft and all period outputs hold.
  - gamePeriod is forced low so the divider stops symbol generation.
- **When undefined:** the port is absent and behaviour is exactly as above.

Decomposition:
- **Shared package:** the state enum type; the per-phase default duration constants; the 7-bit secondsLeft width constant. The display and scoring blocks import these.
- **Sub-module:** phase_timer — a loadable 7-bit down-counter.
  - Inputs: load, load value, tick, hold.
  - Output: expire (secondsLeft==1 && tick && !hold).
  - The FSM instantiates one.

Test Plan:
- Bench parameters: PRELIM_SEC=2, GAME_SEC=3, ANSWER_SEC=2, POST_SEC=1, MAX_LEVEL=2. Clk1Hz is driven as a 1-cycle pulse every 10 cycles.
1. Reset release, start pulse → clkReset=1 for one cycle; prelimPeriod=1, secondsLeft=2. After 2 ticks, gamePeriod=1 with secondsLeft=3; after 3 more ticks, answerPeriod=1.
2. In ANSWER, answerValid=1 with answerCorrect=1 → postPeriod next cycle. After 1 tick: level 1→2, levelChng high exactly one cycle, prelimPeriod=1.
3. Level 2, correct answer, POST expires → gameOver=1, gameWon=1, level=2, all periods 0, no levelChng.
4. No answer during ANSWER → after 2 ticks POST; after 1 more tick gameOver=1, gameWon=0. A later start → level=1, clkReset pulse.
5. answerValid (answerCorrect=1) in the same cycle as the final ANSWER tick → win path taken (POST, then level increment).
6. reset driven low mid-GAME, between clock edges → all outputs 0 and level=1 immediately. With GAME_SEQ_PAUSE_EN, pause=1 across 3 ticks in GAME → secondsLeft unchanged and gamePeriod=0.
